// File: rtl/mont_pre_proc_pipe.sv
// mont_pre_proc_pipe
// Montgomery pre-processing stage. It computes R = (M * 2^SHIFT) mod N and
// moves an operand into the Montgomery domain. It uses binary long division:
// one shift-subtract step per cycle over the WIDTH+SHIFT bit dividend {M, SHIFT zeros}.
//
// Ports:
//   clk        rising-edge clock
//   beg        asynchronous active-low reset
//   in_valid   M/N offered by upstream
//   in_ready   block idle; operands accepted when in_valid && in_ready
//   m_in       operand M (WIDTH bits)
//   n_in       modulus N (WIDTH bits)
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out        result R (WIDTH bits)
//   err        qualified by out_valid: the modulus was zero
//   busy       high while the division steps run
//
// Optional feature: define PRE_PROC_ZERO_SKIP_EN to skip the leading zero bits
// of M at acceptance. This shortens the step sequence and gives identical results.

module mont_pre_proc_pipe #(
    parameter int WIDTH = 256,
    parameter int SHIFT = 256,
    parameter int CNT_W = $clog2(WIDTH + SHIFT + 1)
) (
    input  logic             clk,
    input  logic             beg,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] m_in,
    input  logic [WIDTH-1:0] n_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH + SHIFT - 1);
    localparam logic [CNT_W-1:0] M_STEPS   = CNT_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] m_sr;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH:0]   r_reg;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] cnt_init;
    logic [WIDTH-1:0] m_init;

`ifdef PRE_PROC_ZERO_SKIP_EN
    // Priority encoder: the highest set bit is visited last, so it sets the count.
    logic [CNT_W-1:0] lzc;
    always_comb begin
        lzc = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (m_in[i]) begin
                lzc = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    // Leading zeros of M contribute nothing to the remainder, so skip those steps.
    assign cnt_init = lzc;
    assign m_init   = m_in << lzc;
`else
    assign cnt_init = '0;
    assign m_init   = m_in;
`endif

    // Once the M bits are used up, the dividend continues with SHIFT zero bits.
    logic             step_bit;
    logic [WIDTH+1:0] t_val;
    logic [WIDTH+1:0] n_ext;
    logic [WIDTH+1:0] diff;
    logic [WIDTH+1:0] r_sel;
    logic [WIDTH:0]   r_next;
    logic             unused_top;

    assign step_bit   = (cnt < M_STEPS) ? m_sr[WIDTH-1] : 1'b0;
    assign t_val      = {r_reg, step_bit};
    assign n_ext      = {2'b00, n_reg};
    assign diff       = t_val - n_ext;
    assign r_sel      = (t_val >= n_ext) ? diff : t_val;
    // r < N < 2^WIDTH, so the top bit of the selected value is always zero.
    assign r_next     = r_sel[WIDTH:0];
    assign unused_top = r_sel[WIDTH+1];

    // Control FSM and datapath. All outputs are registered alongside the state.
    // The ">=" on the step count guarantees at least one step. This matters when
    // zero skipping meets SHIFT == 0 and M == 0.
    always_ff @(posedge clk or negedge beg) begin
        if (!beg) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            out       <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            m_sr      <= '0;
            n_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m_sr     <= m_init;
                        n_reg    <= n_in;
                        r_reg    <= '0;
                        cnt      <= cnt_init;
                        in_ready <= 1'b0;
                        if (n_in == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            err       <= 1'b1;
                            out       <= '0;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_next;
                    m_sr  <= m_sr << 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt >= LAST_STEP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out       <= r_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        err       <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_pre_proc_pipe.sv
// tb_mont_pre_proc_pipe
// Directed bench for mont_pre_proc_pipe. It uses three instances:
//   dut_s  WIDTH=8,   SHIFT=8
//   dut_b  WIDTH=256, SHIFT=256
//   dut_z  WIDTH=8,   SHIFT=0  (plain M mod N)
// A table of hand-computed vectors runs through a loop. Hand-written sequences
// cover backpressure and reset during a calculation.

module tb_mont_pre_proc_pipe;

    logic         clk = 1'b0;
    logic         beg;
    logic         out_ready;
    logic         drv_valid;
    logic [255:0] drv_m;
    logic [255:0] drv_n;
    int           sel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic       s_in_valid, s_in_ready, s_out_valid, s_err, s_busy;
    logic [7:0] s_out;
    logic         b_in_valid, b_in_ready, b_out_valid, b_err, b_busy;
    logic [255:0] b_out;
    logic       z_in_valid, z_in_ready, z_out_valid, z_err, z_busy;
    logic [7:0] z_out;

    assign s_in_valid = drv_valid && (sel == 0);
    assign b_in_valid = drv_valid && (sel == 1);
    assign z_in_valid = drv_valid && (sel == 2);

    mont_pre_proc_pipe #(.WIDTH(8), .SHIFT(8)) dut_s (
        .clk(clk), .beg(beg), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .m_in(drv_m[7:0]), .n_in(drv_n[7:0]), .out_valid(s_out_valid),
        .out_ready(out_ready), .out(s_out), .err(s_err), .busy(s_busy)
    );

    mont_pre_proc_pipe dut_b (
        .clk(clk), .beg(beg), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .m_in(drv_m), .n_in(drv_n), .out_valid(b_out_valid),
        .out_ready(out_ready), .out(b_out), .err(b_err), .busy(b_busy)
    );

    mont_pre_proc_pipe #(.WIDTH(8), .SHIFT(0)) dut_z (
        .clk(clk), .beg(beg), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .m_in(drv_m[7:0]), .n_in(drv_n[7:0]), .out_valid(z_out_valid),
        .out_ready(out_ready), .out(z_out), .err(z_err), .busy(z_busy)
    );

    // Route the outputs of the currently selected instance to a common view.
    logic         mx_in_ready, mx_out_valid, mx_err, mx_busy;
    logic [255:0] mx_out;
    always_comb begin
        mx_in_ready  = s_in_ready;
        mx_out_valid = s_out_valid;
        mx_err       = s_err;
        mx_busy      = s_busy;
        mx_out       = {248'd0, s_out};
        case (sel)
            1: begin
                mx_in_ready  = b_in_ready;
                mx_out_valid = b_out_valid;
                mx_err       = b_err;
                mx_busy      = b_busy;
                mx_out       = b_out;
            end
            2: begin
                mx_in_ready  = z_in_ready;
                mx_out_valid = z_out_valid;
                mx_err       = z_err;
                mx_busy      = z_busy;
                mx_out       = {248'd0, z_out};
            end
            default: begin
            end
        endcase
    end

    typedef struct {
        int           which;
        int           w;
        int           s;
        logic [255:0] m;
        logic [255:0] n;
        logic [255:0] exp_out;
        logic         exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_lzc(input logic [255:0] m, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (m[i]) return w - 1 - i;
        end
        return w;
    endfunction

    // Number of clock edges from the accept edge to the edge that raises out_valid.
    // A zero modulus goes straight to DONE on the accept edge itself.
    function automatic int exp_lat(input logic [255:0] m, input logic [255:0] n, input int w, input int s);
        if (n == '0) return 0;
`ifdef PRE_PROC_ZERO_SKIP_EN
        return w + s - ref_lzc(m, w);
`else
        return w + s;
`endif
    endfunction

    // Offer one operation to the selected instance, then scramble the operand
    // bus after acceptance. Wait a bounded time for out_valid.
    task automatic applyStimulus(input int which, input logic [255:0] m, input logic [255:0] n,
                                 output int lat, output logic [255:0] res,
                                 output logic e, output logic ok);
        int g;
        sel = which;
        @(negedge clk);
        drv_m     = m;
        drv_n     = n;
        drv_valid = 1'b1;
        g = 0;
        while (!mx_in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_m     = '1;
        drv_n     = '1;
        lat = 0;
        while (!mx_out_valid && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok  = mx_out_valid;
        res = mx_out;
        e   = mx_err;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           lat;
        logic [255:0] res;
        logic         e;
        logic         ok;
        logic         saw_valid;

        sel       = 0;
        beg       = 1'b1;
        out_ready = 1'b1;
        drv_valid = 1'b0;
        drv_m     = '0;
        drv_n     = '0;

        vecs.push_back('{0, 8, 8, 256'd200, 256'd13,  256'd6,   1'b0});
        vecs.push_back('{0, 8, 8, 256'd55,  256'd0,   256'd0,   1'b1});
        vecs.push_back('{0, 8, 8, 256'd255, 256'd1,   256'd0,   1'b0});
        vecs.push_back('{0, 8, 8, 256'd0,   256'd13,  256'd0,   1'b0});
        vecs.push_back('{0, 8, 8, 256'd1,   256'd13,  256'd9,   1'b0});
        vecs.push_back('{0, 8, 8, 256'd250, 256'd7,   256'd6,   1'b0});
        vecs.push_back('{0, 8, 8, 256'd12,  256'd200, 256'd72,  1'b0});
        vecs.push_back('{0, 8, 8, 256'd128, 256'd255, 256'd128, 1'b0});
        vecs.push_back('{1, 256, 256, 256'd1, {256{1'b1}}, 256'd1, 1'b0});
        vecs.push_back('{1, 256, 256, 256'd0, {256{1'b1}}, 256'd0, 1'b0});
        vecs.push_back('{2, 8, 0, 256'd200, 256'd13,  256'd5,   1'b0});
        vecs.push_back('{2, 8, 0, 256'd13,  256'd13,  256'd0,   1'b0});
        vecs.push_back('{2, 8, 0, 256'd255, 256'd2,   256'd1,   1'b0});

        // Reset values appear as soon as beg falls.
        #2;
        beg = 1'b0;
        #1;
        checkOutput("reset in_ready",  s_in_ready,  1'b1);
        checkOutput("reset out_valid", s_out_valid, 1'b0);
        checkOutput("reset busy",      s_busy,      1'b0);
        checkOutput("reset err",       s_err,       1'b0);
        checkOutput("reset out",       s_out,       8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        beg = 1'b1;

        // Table vectors: result, error flag, latency, then a one-cycle out_valid.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].which, vecs[i].m, vecs[i].n, lat, res, e, ok);
            checkOutput($sformatf("vec%0d out_valid", i), ok, 1'b1);
            checkOutput($sformatf("vec%0d out", i), res, vecs[i].exp_out);
            checkOutput($sformatf("vec%0d err", i), e, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d latency", i), lat,
                        exp_lat(vecs[i].m, vecs[i].n, vecs[i].w, vecs[i].s));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d pulse end", i), mx_out_valid, 1'b0);
            checkOutput($sformatf("vec%0d in_ready back", i), mx_in_ready, 1'b1);
        end

        // Backpressure: hold the result for 5 cycles while ignoring extra in_valid pulses.
        out_ready = 1'b0;
        applyStimulus(0, 256'd200, 256'd13, lat, res, e, ok);
        checkOutput("bp out_valid", ok, 1'b1);
        checkOutput("bp out", res, 256'd6);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drv_valid = (k % 2 == 0);
            drv_m     = 256'd99;
            drv_n     = 256'd5;
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp hold out %0d", k), s_out, 8'd6);
            checkOutput($sformatf("bp hold valid %0d", k), s_out_valid, 1'b1);
            checkOutput($sformatf("bp hold in_ready %0d", k), s_in_ready, 1'b0);
            checkOutput($sformatf("bp hold busy %0d", k), s_busy, 1'b0);
        end
        @(negedge clk);
        drv_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release out_valid", s_out_valid, 1'b0);
        checkOutput("bp release in_ready", s_in_ready, 1'b1);
        applyStimulus(0, 256'd3, 256'd7, lat, res, e, ok);
        checkOutput("b2b out_valid", ok, 1'b1);
        checkOutput("b2b out", res, 256'd5);
        checkOutput("b2b latency", lat, exp_lat(256'd3, 256'd7, 8, 8));
        @(posedge clk);

        // Reset during CALC step 5 discards the partial result.
        sel = 0;
        @(negedge clk);
        drv_m     = 256'd200;
        drv_n     = 256'd13;
        drv_valid = 1'b1;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("mid busy before reset", s_busy, 1'b1);
        beg = 1'b0;
        #1;
        checkOutput("mid reset in_ready",  s_in_ready,  1'b1);
        checkOutput("mid reset out_valid", s_out_valid, 1'b0);
        checkOutput("mid reset busy",      s_busy,      1'b0);
        checkOutput("mid reset err",       s_err,       1'b0);
        checkOutput("mid reset out",       s_out,       8'd0);
        saw_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (s_out_valid) saw_valid = 1'b1;
        end
        checkOutput("mid reset no out_valid", saw_valid, 1'b0);
        @(negedge clk);
        beg = 1'b1;
        applyStimulus(0, 256'd200, 256'd13, lat, res, e, ok);
        checkOutput("post reset out_valid", ok, 1'b1);
        checkOutput("post reset out", res, 256'd6);
        checkOutput("post reset err", e, 1'b0);
        checkOutput("post reset latency", lat, exp_lat(256'd200, 256'd13, 8, 8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
